// File: rtl/core_pkg.sv
// Shared definitions for the store buffer: sequencer state encoding and word-address slice.
// Word addresses drop the two byte-offset bits; all address matching uses [AW-1:WORD_LSB].
package core_pkg;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_REQ  = 2'd1,
        SB_WAIT = 2'd2
    } sb_state_e;

    localparam int WORD_LSB = 2;

endpackage

// File: rtl/sbuf_match.sv
// Parallel word-address comparator across all store-buffer entries.
// Purely combinational; invalid entries never match, byte masks are ignored.
module sbuf_match
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic [AW-1:0]    entry_addr_i [DEPTH],
    input  logic [DEPTH-1:0] entry_vld_i,
    input  logic [AW-1:0]    ld_addr_i,
    output logic             conflict_o
);

    logic [DEPTH-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = entry_vld_i[i] &&
                     (entry_addr_i[i][AW-1:WORD_LSB] == ld_addr_i[AW-1:WORD_LSB]);
        end
    end

    assign conflict_o = |hit;

endmodule

// File: rtl/store_buffer_ctrl.sv
// In-order store buffer: two-wide enqueue, one outstanding memory store, retire on matching finish.
// First request two edges after enqueue into an empty queue; upstream stalls while free entries < 2.
module store_buffer_ctrl
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enqA_valid,
    input  logic [AW-1:0]            enqA_addr,
    input  logic [DW-1:0]            enqA_data,
    input  logic [DW/8-1:0]          enqA_mask,
    input  logic                     enqB_valid,
    input  logic [AW-1:0]            enqB_addr,
    input  logic [DW-1:0]            enqB_data,
    input  logic [DW/8-1:0]          enqB_mask,
    output logic                     enq_ready,
    output logic                     mem_req_valid,
    output logic [AW-1:0]            mem_req_addr,
    output logic [DW-1:0]            mem_req_data,
    output logic [DW/8-1:0]          mem_req_mask,
    input  logic                     mem_req_ready,
    input  logic                     store_finish,
    input  logic [AW-1:0]            store_fin_addr,
    input  logic [AW-1:0]            ld_check_addr,
    output logic                     ld_conflict,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     fin_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW/8-1:0]  mask_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    sb_state_e        state_q, state_d;
    logic             fin_err_q, fin_err_d;

    logic             acc_a, acc_b, head_match, pop;
    logic [CW-1:0]    enq_n;
    logic [PW-1:0]    slot_a, slot_b;

    // Readiness comes from registered occupancy only, so a same-cycle pop never raises it.
    assign enq_ready  = (count_q <= CW'(DEPTH - 2));
    assign acc_a      = enqA_valid && enq_ready;
    assign acc_b      = enqB_valid && enq_ready;
    assign enq_n      = CW'(acc_a) + CW'(acc_b);
    assign slot_a     = wr_ptr_q;
    assign slot_b     = acc_a ? wr_ptr_q + PW'(1) : wr_ptr_q;
    assign head_match = store_finish &&
                        (store_fin_addr[AW-1:WORD_LSB] == addr_q[rd_ptr_q][AW-1:WORD_LSB]);
    assign pop        = (state_q == SB_WAIT) && head_match;

    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q + enq_n[PW-1:0];
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + enq_n - CW'(pop);
        if (pop)   vld_d[rd_ptr_q] = 1'b0;
        if (acc_a) vld_d[slot_a]   = 1'b1;
        if (acc_b) vld_d[slot_b]   = 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        fin_err_d     = fin_err_q;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        mem_req_mask  = '0;
        case (state_q)
            SB_IDLE: if (count_q != '0) state_d = SB_REQ;
            SB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q[rd_ptr_q];
                mem_req_data  = data_q[rd_ptr_q];
                mem_req_mask  = mask_q[rd_ptr_q];
                if (mem_req_ready) state_d = SB_WAIT;
            end
            SB_WAIT: if (pop) state_d = SB_IDLE;
            default: state_d = SB_IDLE;
        endcase
        if (store_finish && !pop) fin_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= SB_IDLE;
            fin_err_q <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            fin_err_q <= fin_err_d;
        end
    end

    // Payload storage needs no reset; the valid vector qualifies every use.
    always_ff @(posedge clk) begin
        if (acc_a) begin
            addr_q[slot_a] <= enqA_addr;
            data_q[slot_a] <= enqA_data;
            mask_q[slot_a] <= enqA_mask;
        end
        if (acc_b) begin
            addr_q[slot_b] <= enqB_addr;
            data_q[slot_b] <= enqB_data;
            mask_q[slot_b] <= enqB_mask;
        end
    end

    sbuf_match #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_match (
        .entry_addr_i(addr_q),
        .entry_vld_i (vld_q),
        .ld_addr_i   (ld_check_addr),
        .conflict_o  (ld_conflict)
    );

    assign count   = count_q;
    assign fin_err = fin_err_q;

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Scenario bench for store_buffer_ctrl with an in-order scoreboard of expected memory requests.
module tb_store_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enqA_valid = 0, enqB_valid = 0;
    logic [31:0] enqA_addr = 0, enqA_data = 0, enqB_addr = 0, enqB_data = 0;
    logic [3:0]  enqA_mask = 0, enqB_mask = 0;
    logic        enq_ready, mem_req_valid, mem_req_ready = 0;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        store_finish = 0;
    logic [31:0] store_fin_addr = 0, ld_check_addr = 0;
    logic        ld_conflict, fin_err;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    store_buffer_ctrl #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .enqA_valid(enqA_valid), .enqA_addr(enqA_addr), .enqA_data(enqA_data), .enqA_mask(enqA_mask),
        .enqB_valid(enqB_valid), .enqB_addr(enqB_addr), .enqB_data(enqB_data), .enqB_mask(enqB_mask),
        .enq_ready(enq_ready),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask), .mem_req_ready(mem_req_ready),
        .store_finish(store_finish), .store_fin_addr(store_fin_addr),
        .ld_check_addr(ld_check_addr), .ld_conflict(ld_conflict),
        .count(count), .fin_err(fin_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic push_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        exp_t x;
        enqA_valid = 1; enqA_addr = a; enqA_data = d; enqA_mask = m;
        x.addr = a; x.data = d; x.mask = m;
        sbq.push_back(x);
    endtask

    task automatic push_b(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        exp_t x;
        enqB_valid = 1; enqB_addr = a; enqB_data = d; enqB_mask = m;
        x.addr = a; x.data = d; x.mask = m;
        sbq.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1;
        step(); step();
        rst = 0;
        sbq.delete();
        chk_cnt++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
        chk_cnt++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %b want 0", mem_req_valid); else pass_cnt++;
        chk_cnt++;
        if ({mem_req_addr, mem_req_data, mem_req_mask} !== 68'd0)
            $display("FAIL reset_req_fields got %h/%h/%h want 0", mem_req_addr, mem_req_data, mem_req_mask);
        else pass_cnt++;
        chk_cnt++; if (fin_err !== 1'b0) $display("FAIL reset_fin_err got %b want 0", fin_err); else pass_cnt++;
        chk_cnt++; if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready got %b want 1", enq_ready); else pass_cnt++;
        chk_cnt++; if (ld_conflict !== 1'b0) $display("FAIL reset_ld_conflict got %b want 0", ld_conflict); else pass_cnt++;
    endtask

    task automatic test_single();
        push_a(32'h100, 32'hDEADBEEF, 4'hF);
        step();
        enqA_valid = 0;
        chk_cnt++; if (count !== 3'd1) $display("FAIL single_count got %0d want 1", count); else pass_cnt++;
        chk_cnt++; if (mem_req_valid !== 1'b0) $display("FAIL single_early_req got %b want 0", mem_req_valid); else pass_cnt++;
        step();
        e = sbq.pop_front();
        chk_cnt++; if (mem_req_valid !== 1'b1) $display("FAIL single_req_valid got %b want 1", mem_req_valid); else pass_cnt++;
        chk_cnt++;
        if (mem_req_addr !== e.addr || mem_req_data !== e.data || mem_req_mask !== e.mask)
            $display("FAIL single_req_fields got %h/%h/%h want %h/%h/%h",
                     mem_req_addr, mem_req_data, mem_req_mask, e.addr, e.data, e.mask);
        else pass_cnt++;
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        chk_cnt++; if (mem_req_valid !== 1'b0) $display("FAIL single_wait_valid got %b want 0", mem_req_valid); else pass_cnt++;
        store_finish = 1; store_fin_addr = e.addr;
        step();
        store_finish = 0;
        chk_cnt++; if (count !== 3'd0) $display("FAIL single_pop_count got %0d want 0", count); else pass_cnt++;
        chk_cnt++; if (fin_err !== 1'b0) $display("FAIL single_fin_err got %b want 0", fin_err); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        push_a(32'h200, 32'hA0A0A0A0, 4'hF);
        push_b(32'h204, 32'hB0B0B0B0, 4'hC);
        step();
        enqA_valid = 0; enqB_valid = 0;
        chk_cnt++; if (count !== 3'd2) $display("FAIL b2b_count got %0d want 2", count); else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            wait_req(ok);
            chk_cnt++; if (!ok) $display("FAIL b2b_req_timeout got none want request %0d", k); else pass_cnt++;
            e = sbq.pop_front();
            chk_cnt++;
            if (mem_req_addr !== e.addr || mem_req_data !== e.data || mem_req_mask !== e.mask)
                $display("FAIL b2b_order got %h/%h/%h want %h/%h/%h",
                         mem_req_addr, mem_req_data, mem_req_mask, e.addr, e.data, e.mask);
            else pass_cnt++;
            mem_req_ready = 1;
            step();
            mem_req_ready = 0;
            step(); step(); step();
            chk_cnt++;
            if (mem_req_valid !== 1'b0 || count !== 3'(2 - k))
                $display("FAIL b2b_waits_finish got valid=%b count=%0d want 0/%0d", mem_req_valid, count, 2 - k);
            else pass_cnt++;
            store_finish = 1; store_fin_addr = e.addr;
            step();
            store_finish = 0;
            chk_cnt++; if (count !== 3'(1 - k)) $display("FAIL b2b_pop_count got %0d want %0d", count, 1 - k); else pass_cnt++;
        end
        chk_cnt++; if (fin_err !== 1'b0) $display("FAIL b2b_fin_err got %b want 0", fin_err); else pass_cnt++;
    endtask

    task automatic test_hold();
        bit ok;
        push_a(32'h400, 32'h12345678, 4'h3);
        step();
        enqA_valid = 0;
        wait_req(ok);
        chk_cnt++; if (!ok) $display("FAIL hold_req_timeout got none want request"); else pass_cnt++;
        e = sbq.pop_front();
        for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== e.addr || mem_req_data !== e.data || mem_req_mask !== e.mask)
                $display("FAIL hold_stable cycle %0d got %b %h/%h/%h want 1 %h/%h/%h", i,
                         mem_req_valid, mem_req_addr, mem_req_data, mem_req_mask, e.addr, e.data, e.mask);
            else pass_cnt++;
            step();
        end
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        step(); step();
        chk_cnt++;
        if (mem_req_valid !== 1'b0 || count !== 3'd1)
            $display("FAIL hold_one_handshake got valid=%b count=%0d want 0/1", mem_req_valid, count);
        else pass_cnt++;
        store_finish = 1; store_fin_addr = e.addr;
        step();
        store_finish = 0;
        chk_cnt++; if (count !== 3'd0) $display("FAIL hold_pop_count got %0d want 0", count); else pass_cnt++;
    endtask

    task automatic test_full();
        bit ok;
        push_a(32'h500, 32'h55550000, 4'hF);
        push_b(32'h504, 32'h55550004, 4'hF);
        step();
        enqB_valid = 0;
        chk_cnt++; if (enq_ready !== 1'b1) $display("FAIL full_ready_at2 got %b want 1", enq_ready); else pass_cnt++;
        push_a(32'h508, 32'h55550008, 4'h1);
        step();
        chk_cnt++; if (count !== 3'd3 || enq_ready !== 1'b0)
            $display("FAIL full_at3 got count=%0d ready=%b want 3/0", count, enq_ready);
        else pass_cnt++;
        enqA_addr = 32'h50C; enqA_data = 32'h5555000C;
        step();
        enqA_valid = 0;
        chk_cnt++; if (count !== 3'd3) $display("FAIL full_ignored got %0d want 3", count); else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            wait_req(ok);
            e = sbq.pop_front();
            chk_cnt++;
            if (!ok || mem_req_addr !== e.addr)
                $display("FAIL full_order got ok=%b addr=%h want 1/%h", ok, mem_req_addr, e.addr);
            else pass_cnt++;
            mem_req_ready = 1;
            step();
            mem_req_ready = 0;
            store_finish = 1; store_fin_addr = e.addr;
            if (k == 1) push_a(32'h510, 32'h55550010, 4'h8);
            step();
            store_finish = 0; enqA_valid = 0;
            chk_cnt++; if (count !== 3'd2) $display("FAIL full_pop%0d_count got %0d want 2", k, count); else pass_cnt++;
        end
        while (sbq.size() > 0) begin
            wait_req(ok);
            e = sbq.pop_front();
            chk_cnt++;
            if (!ok || mem_req_addr !== e.addr || mem_req_data !== e.data || mem_req_mask !== e.mask)
                $display("FAIL full_drain got ok=%b %h/%h/%h want %h/%h/%h", ok,
                         mem_req_addr, mem_req_data, mem_req_mask, e.addr, e.data, e.mask);
            else pass_cnt++;
            mem_req_ready = 1;
            step();
            mem_req_ready = 0;
            store_finish = 1; store_fin_addr = e.addr;
            step();
            store_finish = 0;
        end
        chk_cnt++; if (count !== 3'd0) $display("FAIL full_drained got %0d want 0", count); else pass_cnt++;
    endtask

    task automatic test_conflict();
        bit ok;
        push_a(32'h300, 32'h33333333, 4'hF);
        step();
        enqA_valid = 0;
        ld_check_addr = 32'h302; #1;
        chk_cnt++; if (ld_conflict !== 1'b1) $display("FAIL conf_same_word got %b want 1", ld_conflict); else pass_cnt++;
        ld_check_addr = 32'h304; #1;
        chk_cnt++; if (ld_conflict !== 1'b0) $display("FAIL conf_next_word got %b want 0", ld_conflict); else pass_cnt++;
        wait_req(ok);
        e = sbq.pop_front();
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        ld_check_addr = 32'h301; #1;
        chk_cnt++; if (ld_conflict !== 1'b1) $display("FAIL conf_head_wait got %b want 1", ld_conflict); else pass_cnt++;
        store_finish = 1; store_fin_addr = 32'h304;
        step();
        store_finish = 0;
        chk_cnt++; if (fin_err !== 1'b1 || count !== 3'd1)
            $display("FAIL conf_bad_finish got err=%b count=%0d want 1/1", fin_err, count);
        else pass_cnt++;
        store_finish = 1; store_fin_addr = e.addr;
        step();
        store_finish = 0;
        chk_cnt++; if (count !== 3'd0 || fin_err !== 1'b1)
            $display("FAIL conf_good_finish got count=%0d err=%b want 0/1", count, fin_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        rst = 1; step(); rst = 0;
        sbq.delete();
        chk_cnt++; if (fin_err !== 1'b0) $display("FAIL rmid_err_clear got %b want 0", fin_err); else pass_cnt++;
        push_a(32'h600, 32'h66666666, 4'hF);
        push_b(32'h604, 32'h66666667, 4'hF);
        step();
        enqA_valid = 0; enqB_valid = 0;
        wait_req(ok);
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        chk_cnt++; if (!ok || count !== 3'd2 || mem_req_valid !== 1'b0)
            $display("FAIL rmid_in_wait got ok=%b count=%0d valid=%b want 1/2/0", ok, count, mem_req_valid);
        else pass_cnt++;
        rst = 1; step(); rst = 0;
        sbq.delete();
        ld_check_addr = 32'h600; #1;
        chk_cnt++; if (count !== 3'd0 || mem_req_valid !== 1'b0 || ld_conflict !== 1'b0 || enq_ready !== 1'b1)
            $display("FAIL rmid_cleared got count=%0d valid=%b conf=%b ready=%b want 0/0/0/1",
                     count, mem_req_valid, ld_conflict, enq_ready);
        else pass_cnt++;
        store_finish = 1; store_fin_addr = 32'h600;
        step();
        store_finish = 0;
        step();
        chk_cnt++; if (fin_err !== 1'b1 || mem_req_valid !== 1'b0)
            $display("FAIL rmid_late_finish got err=%b valid=%b want 1/0", fin_err, mem_req_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_full();
        test_conflict();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
